// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Opcodes, FSM states and datapath mux encodings for mcycle_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_t;

  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RD1 = 2'd2, SRCA_ZERO = 2'd3} srca_t;
  typedef enum logic [1:0] {SRCB_RD2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} srcb_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_READDATA = 2'd1, RES_ALURESULT = 2'd2} res_t;
  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_t;
  typedef enum logic [1:0] {ALUOP_ADD = 2'd0, ALUOP_SUB = 2'd1, ALUOP_FUNCT = 2'd2} aluop_t;

  // funct3 010/011 are unassigned branch encodings and must trap.
  function automatic logic branch_legal(input logic [2:0] funct3);
    return funct3[2:1] != 2'b01;
  endfunction

  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic neg, input logic ult);
    logic cond;
    case (funct3[2:1])
      2'b00:   cond = zero;
      2'b10:   cond = neg;
      2'b11:   cond = ult;
      default: cond = 1'b0;
    endcase
    return branch_legal(funct3) && (cond ^ funct3[0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcycle_ctrl_if.sv
// ============================================================================
// Module   : mcycle_ctrl_if
// Purpose  : Decode inputs, memory handshake and datapath controls.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mcycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       ZeroFlag;
  logic       NegativeFlag;
  logic       UnsignedLess;
  logic       mem_ready;
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [1:0] ALUop;

  modport master (
    input  opcode, funct3, ZeroFlag, NegativeFlag, UnsignedLess, mem_ready,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUop
  );

  modport slave (
    output opcode, funct3, ZeroFlag, NegativeFlag, UnsignedLess, mem_ready,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUop
  );
endinterface

`default_nettype wire

// File: rtl/perf_counters.sv
// ============================================================================
// Module   : perf_counters
// Purpose  : Free-running cycle and retired-instruction counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module perf_counters #(
  parameter int CNT_WIDTH = 32
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 cycle_en,
  input  wire logic                 instret_en,
  output logic     [CNT_WIDTH-1:0]  cycle_cnt,
  output logic     [CNT_WIDTH-1:0]  instret_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cycle_en)   cycle_cnt   <= cycle_cnt + CNT_ONE;
      if (instret_en) instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcycle_ctrl.sv
// ============================================================================
// Module   : mcycle_ctrl
// Purpose  : Multicycle RV32 control FSM with sticky trap and perf counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcycle_ctrl
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  mcycle_ctrl_if.master             bus,
  output logic                      trap,
  output logic     [CNT_WIDTH-1:0]  cycle_cnt,
  output logic     [CNT_WIDTH-1:0]  instret_cnt
);

  state_t state, next_state;
  logic   ready;
  logic   instret_en;

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("mcycle_ctrl: DATA_WIDTH must be positive");
  end

  if (MEM_WAIT_EN) begin : g_mem_wait
    assign ready = bus.mem_ready;
  end else begin : g_no_wait
    assign ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (ready) next_state = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: next_state = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ready) next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  if (ready) next_state = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI: next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = branch_legal(bus.funct3) ? S_FETCH : S_TRAP;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    bus.MemReq    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RD2;
    bus.ResultSrc = RES_ALUOUT;
    bus.ImmSrc    = IMM_I;
    bus.ALUop     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        bus.MemReq    = 1'b1;
        bus.IRWrite   = ready;
        bus.PCWrite   = ready;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMRD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite  = 1'b1;
        bus.ResultSrc = RES_READDATA;
      end
      S_MEMWR: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUop   = ALUOP_FUNCT;
      end
      S_ALUWB: bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUop   = ALUOP_SUB;
        bus.PCWrite = branch_taken(bus.funct3, bus.ZeroFlag, bus.NegativeFlag, bus.UnsignedLess);
      end
      S_JAL: begin
        // ALU out already holds the target from DECODE; ALU computes the link.
        bus.PCWrite = 1'b1;
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
      end
      S_JALR: begin
        bus.PCWrite   = 1'b1;
        bus.ALUSrcA   = SRCA_RD1;
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALURESULT;
      end
      S_LUI: begin
        bus.ALUSrcA = SRCA_ZERO;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = IMM_U;
      end
      default: ;
    endcase
    // A reset cycle abandons any in-flight access without side effects.
    if (!rst) begin
      bus.MemReq   = 1'b0;
      bus.MemWrite = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end

  assign trap = (state == S_TRAP);

  assign instret_en = (state == S_MEMWB) || (state == S_ALUWB) ||
                      ((state == S_MEMWR) && ready) ||
                      ((state == S_BRANCH) && branch_legal(bus.funct3));

  perf_counters #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .cycle_en    (state != S_TRAP),
    .instret_en  (instret_en),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
// ============================================================================
// Module   : tb_mcycle_ctrl
// Purpose  : Scoreboard bench: per-instruction cost model vs. mcycle_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mcycle_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trap, trap4;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [3:0]  cycle4, instret4;

  always #5 clk = ~clk;

  mcycle_ctrl_if bus ();
  mcycle_ctrl_if bus4 ();

  assign bus4.opcode       = bus.opcode;
  assign bus4.funct3       = bus.funct3;
  assign bus4.ZeroFlag     = bus.ZeroFlag;
  assign bus4.NegativeFlag = bus.NegativeFlag;
  assign bus4.UnsignedLess = bus.UnsignedLess;
  assign bus4.mem_ready    = bus.mem_ready;

  mcycle_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(32), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .trap(trap),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  mcycle_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(4), .MEM_WAIT_EN(1'b1)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .trap(trap4),
    .cycle_cnt(cycle4), .instret_cnt(instret4)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z, n, u;
  } instr_t;

  typedef struct {
    int cycles, memreq, memwr, regw, pcw, irw, fn, cmp;
  } exp_t;

  instr_t iq[$];
  int     wq[$];
  exp_t   sb[$];
  int     checks = 0;
  int     fails  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cost of one instruction from the architectural rules, given its waits.
  function automatic exp_t model(input instr_t i, input int fw, input int mw);
    exp_t e;
    logic taken;
    e = '{cycles: fw + 2, memreq: fw + 1, memwr: 0, regw: 1, pcw: 1, irw: 1, fn: 0, cmp: 0};
    case (i.op)
      OP_LOAD:  begin e.cycles += mw + 3; e.memreq += mw + 1; end
      OP_STORE: begin e.cycles += mw + 2; e.memreq += mw + 1; e.memwr = mw + 1; e.regw = 0; end
      OP_R, OP_I: begin e.cycles += 2; e.fn = 1; end
      OP_LUI:   e.cycles += 2;
      OP_JAL, OP_JALR: begin e.cycles += 2; e.pcw = 2; end
      default: begin
        e.cycles += 1; e.regw = 0; e.cmp = 1;
        case (i.f3)
          3'd0: taken = i.z;
          3'd1: taken = !i.z;
          3'd4: taken = i.n;
          3'd5: taken = !i.n;
          3'd6: taken = i.u;
          default: taken = !i.u;
        endcase
        if (taken) e.pcw = 2;
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input logic n, input logic u, input int fw, input int mw);
    instr_t i;
    i = '{op: op, f3: f3, z: z, n: n, u: u};
    iq.push_back(i);
    wq.push_back(fw);
    if (op == OP_LOAD || op == OP_STORE) wq.push_back(mw);
    sb.push_back(model(i, fw, mw));
  endtask

  // Memory / instruction source: grants each request after its wait count.
  int mcnt = 0;
  always @(posedge clk) begin
    instr_t i;
    #2;
    if (!rst) begin
      bus.mem_ready = 1'b0;
      mcnt = 0;
      if (iq.size() == 0 && bus.opcode === 7'bx) begin
        bus.opcode = '0; bus.funct3 = '0;
        bus.ZeroFlag = 1'b0; bus.NegativeFlag = 1'b0; bus.UnsignedLess = 1'b0;
      end
    end else if (bus.MemReq && wq.size() > 0) begin
      if (mcnt == wq[0]) begin
        bus.mem_ready = 1'b1;
        void'(wq.pop_front());
        mcnt = 0;
        if (!bus.AdrSrc && iq.size() > 0) begin
          i = iq.pop_front();
          bus.opcode = i.op; bus.funct3 = i.f3;
          bus.ZeroFlag = i.z; bus.NegativeFlag = i.n; bus.UnsignedLess = i.u;
        end
      end else begin
        bus.mem_ready = 1'b0;
        mcnt++;
      end
    end else begin
      bus.mem_ready = 1'b0;
    end
  end

  // Monitor: a retirement closes a segment, which is scored against the model.
  int     seg_cyc, seg_req, seg_wr, seg_rw, seg_pw, seg_ir, seg_fn, seg_cmp;
  int     nret, elapsed;
  longint tot;
  logic [31:0] last_ir;
  bit     wrap_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      {seg_cyc, seg_req, seg_wr, seg_rw, seg_pw, seg_ir, seg_fn, seg_cmp} = '0;
      nret = 0; elapsed = 0; tot = 0; last_ir = '0;
    end else begin
      if (instret_cnt !== last_ir) begin
        last_ir = instret_cnt;
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_retire: instret %0d with empty scoreboard", instret_cnt);
        end else begin
          e = sb.pop_front();
          nret++;
          tot += e.cycles;
          check("instr_cycles", seg_cyc, e.cycles);
          check("memreq_cycles", seg_req, e.memreq);
          check("memwrite_cycles", seg_wr, e.memwr);
          check("regwrite_pulses", seg_rw, e.regw);
          check("pcwrite_pulses", seg_pw, e.pcw);
          check("irwrite_pulses", seg_ir, e.irw);
          check("aluop_funct", seg_fn, e.fn);
          check("aluop_cmp", seg_cmp, e.cmp);
          check("instret_cnt", instret_cnt, nret);
          check("cycle_cnt", cycle_cnt, tot);
          check("cycle_cnt_w4", cycle4, tot % 16);
          check("instret_cnt_w4", instret4, nret % 16);
        end
        {seg_cyc, seg_req, seg_wr, seg_rw, seg_pw, seg_ir, seg_fn, seg_cmp} = '0;
      end
      if (elapsed == 17 && !wrap_done) begin
        wrap_done = 1'b1;
        check("cycle_cnt_w4_wrap17", cycle4, 1);
      end
      elapsed++;
      seg_cyc++;
      seg_req += int'(bus.MemReq);
      seg_wr  += int'(bus.MemWrite);
      seg_rw  += int'(bus.RegWrite);
      seg_pw  += int'(bus.PCWrite);
      seg_ir  += int'(bus.IRWrite);
      seg_fn  += int'(bus.ALUop == 2'd2);
      seg_cmp += int'(bus.ALUop == 2'd1);
    end
  end

  initial begin
    logic [6:0] ops [8];
    int         legal_br [6];
    logic [6:0] op;
    logic [2:0] f3;
    int         t, frz;

    ops      = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
    legal_br = '{0, 1, 4, 5, 6, 7};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_memreq", bus.MemReq, 0);
    check("rst_regwrite", bus.RegWrite, 0);
    check("rst_trap", trap, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_instret_cnt", instret_cnt, 0);

    issue(OP_R, 3'd0, 0, 0, 0, 0, 0);         // add x3,x1,x2
    issue(OP_LOAD, 3'd2, 0, 0, 0, 0, 3);      // lw, 3 wait cycles
    issue(OP_BRANCH, 3'd0, 1, 0, 0, 0, 0);    // beq taken
    issue(OP_BRANCH, 3'd0, 0, 0, 0, 1, 0);    // beq not taken
    issue(OP_BRANCH, 3'd6, 0, 0, 1, 0, 0);    // bltu taken
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 7)];
      f3 = (op == OP_BRANCH) ? 3'(legal_br[$urandom_range(0, 5)]) : 3'($urandom_range(0, 7));
      issue(op, f3, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 4));
    end

    @(posedge clk); #1 rst = 1'b1;
    t = 0;
    while (sb.size() > 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      checks++; fails++;
      $display("FAIL program_timeout: %0d instructions outstanding, expected 0", sb.size());
      sb.delete();
    end

    // Illegal opcode: sticky trap with frozen cycle counter.
    iq.push_back('{op: 7'b0000000, f3: 3'd0, z: 1'b0, n: 1'b0, u: 1'b0});
    wq.push_back(0);
    t = 0;
    while (trap !== 1'b1 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    check("trap_set", trap, 1);
    frz = elapsed - 1;
    check("trap_cycle_at_entry", cycle_cnt, frz);
    repeat (5) @(negedge clk);
    #1;
    check("trap_cycle_frozen", cycle_cnt, frz);
    check("trap_sticky", trap, 1);
    check("trap_no_memreq", bus.MemReq, 0);
    check("trap_no_pcwrite", bus.PCWrite, 0);

    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    check("trap_cleared", trap, 0);
    check("trap_rst_cycle_cnt", cycle_cnt, 0);
    check("post_rst_fetch_memreq", bus.MemReq, 1);

    // Reset while a store is stalled on memory.
    iq.push_back('{op: OP_STORE, f3: 3'd2, z: 1'b0, n: 1'b0, u: 1'b0});
    wq.push_back(0);
    wq.push_back(50);
    t = 0;
    while (bus.MemWrite !== 1'b1 && t < 30) begin
      @(negedge clk); #1;
      t++;
    end
    check("memwr_reached", bus.MemWrite, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    wq.delete();
    iq.delete();
    @(negedge clk); #1;
    check("rstcyc_memwrite", bus.MemWrite, 0);
    check("rstcyc_memreq", bus.MemReq, 0);
    check("rstcyc_regwrite", bus.RegWrite, 0);
    check("rstcyc_pcwrite", bus.PCWrite, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    check("after_rst_memwrite", bus.MemWrite, 0);
    check("after_rst_fetch_memreq", bus.MemReq, 1);
    check("after_rst_adrsrc", bus.AdrSrc, 0);
    check("after_rst_cycle_cnt", cycle_cnt, 0);
    check("after_rst_instret_cnt", instret_cnt, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 32, datapath width for counters and flag context.
REQ-002 Parameter: CNT_WIDTH, 32, width of cycle and retired-instruction counters.
REQ-003 Parameter: MEM_WAIT_EN, 1, when 1 memory states wait on mem_ready; when 0 mem_ready is ignored and treated as 1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 opcode  in  7  instr[6:0] of the latched instruction register.
REQ-007 funct3  in  3  instr[14:12].
REQ-008 ZeroFlag, NegativeFlag, UnsignedLess  in  1 each  ALU flags for the current compare.
REQ-009 mem_ready  in  1  memory completes the current request this cycle.
REQ-010 MemReq  out  1  memory request valid.
REQ-011 MemWrite  out  1  request is a write.
REQ-012 AdrSrc  out  1  0 = PC address, 1 = ALU result address.
REQ-013 IRWrite, PCWrite, RegWrite  out  1 each  register enables.
REQ-014 ALUSrcA  out  2  0 PC, 1 old PC, 2 RD1.
REQ-015 ALUSrcB  out  2  0 RD2, 1 ImmExt, 2 constant 4.
REQ-016 ResultSrc  out  2  0 ALU out reg, 1 ReadData, 2 ALUResult.
REQ-017 ImmSrc  out  3  immediate format select.
REQ-018 ALUop  out  2  to ALU decode: 0 add, 1 compare/sub, 2 funct-decoded.
REQ-019 trap  out  1  illegal opcode detected; sticky.
REQ-020 cycle_cnt, instret_cnt  out  CNT_WIDTH each  performance counters.

Function
REQ-021 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
REQ-022 FETCH: MemReq=1, AdrSrc=0; on mem_ready IRWrite=1, PCWrite=1 (PC+4) in that same cycle, go DECODE; else stay with all enables 0.
REQ-023 DECODE: ALU computes PC+ImmExt (B-type) into ALU out reg; next state by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, other TRAP.
REQ-024 MEMADR -> MEMRD for load, MEMWR for store.
REQ-025 MEMRD: MemReq=1, AdrSrc=1; wait on mem_ready, then MEMWB. MEMWB: RegWrite=1, ResultSrc=1 -> FETCH.
REQ-026 MEMWR: MemReq=1, MemWrite=1, AdrSrc=1; wait on mem_ready, then FETCH.
REQ-027 EXECR/EXECI: ALUop=2 -> ALUWB; ALUWB: RegWrite=1, ResultSrc=0 -> FETCH.
REQ-028 BRANCH: ALUop=1; PCWrite=1 with ResultSrc=0 iff taken; taken per funct3: 000 Zero, 001 !Zero, 100 Negative, 101 !Negative, 110 UnsignedLess, 111 !UnsignedLess; 010/011 TRAP; else -> FETCH.
REQ-029 JAL/JALR: PCWrite=1 to target, old PC+4 into ALUWB path -> ALUWB. LUI -> ALUWB with ALUSrcA selecting zero via ImmSrc U.
REQ-030 TRAP: all enables 0, trap=1; remains until reset.
REQ-031 Outputs not named active in a state are 0; MemReq held stable while waiting.
REQ-032 cycle_cnt increments every cycle out of reset, except in TRAP; wraps modulo 2^CNT_WIDTH.
REQ-033 instret_cnt increments once on the cycle an instruction leaves its final state (MEMWB, MEMWR accepted, ALUWB, BRANCH); wraps.
REQ-034 Waits are unbounded; no timeout.

Reset
REQ-035 rst low at a rising edge: state FETCH, trap 0, both counters 0, all enables 0 on following cycle.
REQ-036 Reset mid-wait abandons the in-flight request; no write enable asserted in the reset cycle.

Structure
REQ-037 Opcode constants, state enum, ALUSrcA/B and ResultSrc encodings in shared package riscv_pkg.
REQ-038 Sub-module perf_counters holds both counters; FSM in mcycle_ctrl.

Verification
REQ-039 add x3,x1,x2 with mem_ready always 1 -> FETCH,DECODE,EXECR,ALUWB; RegWrite one cycle; instret 0->1 after 4 cycles.
REQ-040 lw with mem_ready low 3 cycles in MEMRD -> MemReq held 4 cycles, MEMWB once, load takes 8 cycles total.
REQ-041 beq Zero=1 -> PCWrite in BRANCH; Zero=0 -> no PCWrite; bltu UnsignedLess=1 -> taken.
REQ-042 opcode 0000000 -> TRAP, trap=1, cycle_cnt frozen, cleared only by rst low.
REQ-043 CNT_WIDTH=4, 17 cycles -> cycle_cnt wraps to 1.
REQ-044 rst low during MEMWR wait -> next cycle FETCH, MemWrite 0, counters 0.
